// File: rtl/vid_pkg.sv
// vid_pkg: shared pixel word type, output-stage state encoding and word width.
package vid_pkg;

    localparam int PIX_W = 27;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hsync;
        logic       vsync;
        logic       vde;
    } pixel_t;

    typedef enum logic {FILL, STREAM} state_e;

endpackage

// File: rtl/vid_sync_fifo.sv
// vid_sync_fifo: single-clock FIFO with occupancy count and first-word-fall-through head.
module vid_sync_fifo
    import vid_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter type T     = pixel_t
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  T                           data_i,
    output T                           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    T mem_q [DEPTH];
    logic [LW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic do_push, do_pop;

    // Counters carry one extra bit so full and empty stay distinct.
    assign level_o = wr_q - rd_q;
    assign full_o  = level_o == LW'(DEPTH);
    assign empty_o = level_o == '0;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q + LW'(do_push);
        rd_d = rd_q + LW'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i)
        if (do_push && !rst_i) mem_q[wr_q[AW-1:0]] <= data_i;

endmodule

// File: rtl/vid_out_fifo.sv
// vid_out_fifo: replays the processed stream at display rate with prefill, vsync alignment and underflow detect.
// Define VID_OUT_FIFO_STATS_EN to build the saturating underflow counter.
module vid_out_fifo
    import vid_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int PREFILL = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [7:0]                 r_i,
    input  logic [7:0]                 g_i,
    input  logic [7:0]                 b_i,
    input  logic                       hsync_i,
    input  logic                       vsync_i,
    input  logic                       vde_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic                       pix_en_i,
    output logic [7:0]                 r_o,
    output logic [7:0]                 g_o,
    output logic [7:0]                 b_o,
    output logic                       hsync_o,
    output logic                       vsync_o,
    output logic                       vde_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       streaming_o,
    output logic                       underflow_o,
    output logic [15:0]                underflow_cnt_o
);
    localparam int LW = $clog2(DEPTH + 1);

    pixel_t in_pix, head, out_q, out_d;
    state_e state_q, state_d;
    logic full, empty, pop;

    assign in_pix = PIX_W'({r_i, g_i, b_i, hsync_i, vsync_i, vde_i});
    assign ready_o = !full;

    vid_sync_fifo #(.DEPTH(DEPTH), .T(pixel_t)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (valid_i),
        .pop_i   (pop),
        .data_i  (in_pix),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level_o)
    );

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        pop         = 1'b0;
        underflow_o = 1'b0;
        if (state_q == FILL) begin
            out_d = '0;
            // Discard words until a frame start sits at the head with enough buffered behind it.
            if (head.vsync && level_o >= LW'(PREFILL)) state_d = STREAM;
            else if (!empty && !head.vsync) pop = 1'b1;
        end else if (pix_en_i) begin
            pop         = !empty;
            out_d       = empty ? '0 : head;
            underflow_o = empty;
            state_d     = empty ? FILL : STREAM;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FILL;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign {r_o, g_o, b_o, hsync_o, vsync_o, vde_o} = out_q;
    assign streaming_o = state_q == STREAM;

`ifdef VID_OUT_FIFO_STATS_EN
    logic [15:0] ucnt_q, ucnt_d;
    always_comb ucnt_d = (underflow_o && ucnt_q != 16'hFFFF) ? ucnt_q + 16'd1 : ucnt_q;
    always_ff @(posedge clk_i) ucnt_q <= rst_i ? '0 : ucnt_d;
    assign underflow_cnt_o = ucnt_q;
`else
    assign underflow_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_vid_out_fifo.sv
// tb_vid_out_fifo: scoreboard bench; stimulus queues expected display words, a negedge monitor checks them.
module tb_vid_out_fifo;
    import vid_pkg::*;

`ifdef VID_OUT_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk_i = 1'b0, rst_i = 1'b1;
    logic [7:0] r_i = '0, g_i = '0, b_i = '0, r_o, g_o, b_o;
    logic hsync_i = 0, vsync_i = 0, vde_i = 0, valid_i = 0, pix_en_i = 0;
    logic ready_o, hsync_o, vsync_o, vde_o, streaming_o, underflow_o;
    logic [4:0] level_o;
    logic [15:0] underflow_cnt_o;

    int checks = 0, errors = 0, uf_seen = 0, exp_uf = 0;
    logic [15:0] exp_cnt = '0;
    pixel_t exp_q[$];
    pixel_t out_pix;
    bit fire = 0;

    always #5 clk_i = ~clk_i;

    vid_out_fifo #(.DEPTH(16), .PREFILL(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .r_i(r_i), .g_i(g_i), .b_i(b_i),
        .hsync_i(hsync_i), .vsync_i(vsync_i), .vde_i(vde_i), .valid_i(valid_i),
        .ready_o(ready_o), .pix_en_i(pix_en_i), .r_o(r_o), .g_o(g_o), .b_o(b_o),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .vde_o(vde_o), .level_o(level_o),
        .streaming_o(streaming_o), .underflow_o(underflow_o), .underflow_cnt_o(underflow_cnt_o)
    );

    assign out_pix = {r_o, g_o, b_o, hsync_o, vsync_o, vde_o};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic pixel_t mk(input logic [15:0] id, input logic vs, input logic hs);
        return {id[7:0], id[15:8] ^ 8'hA5, ~id[7:0], hs, vs, 1'b1};
    endfunction

    function automatic logic [15:0] bump(input logic [15:0] c);
        return STATS ? (c == 16'hFFFF ? c : c + 16'd1) : 16'h0000;
    endfunction

    // A word popped in STREAM at the next edge must appear on the outputs one negedge later.
    always @(negedge clk_i) begin
        if (fire) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pix_out: got %h, expected no output word", out_pix);
            end else chk("pix_out", out_pix, exp_q.pop_front());
        end
        fire = !rst_i && streaming_o && pix_en_i && level_o != 0;
        if (underflow_o) uf_seen++;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input pixel_t p);
        {r_i, g_i, b_i, hsync_i, vsync_i, vde_i} = p;
    endtask

    task automatic push_word(input pixel_t p, input bit keep);
        drive(p);
        valid_i = 1'b1;
        if (ready_o && keep) exp_q.push_back(p);
        step();
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        pix_en_i = 1'b1;
        while (level_o != 0 && t < 40) begin
            step();
            t++;
        end
        pix_en_i = 1'b0;
        chk("drain_done", level_o, 0);
    endtask

    task automatic run_frame(input int drop, input logic [15:0] base);
        int t;
        for (int i = 0; i < drop; i++) push_word(mk(base + 16'(i), 1'b0, 1'b0), 1'b0);
        for (int i = 0; i < 8; i++) push_word(mk(base + 16'(drop + i), i == 0, i == 0), 1'b1);
        t = 0;
        while (!streaming_o && t < 6) begin
            step();
            t++;
        end
        chk("stream_entry", streaming_o, 1);
        chk("prefill_level", level_o, 8);
        pix_en_i = 1'b1;
        repeat (8) step();
        chk("uf_pulse", underflow_o, 1);
        step();
        pix_en_i = 1'b0;
        exp_uf++;
        exp_cnt = bump(exp_cnt);
        chk("uf_to_fill", streaming_o, 0);
        chk("uf_blank", out_pix, 0);
        chk("uf_cnt", underflow_cnt_o, exp_cnt);
    endtask

    initial begin
        int acc, t;
        step();
        step();
        chk("rst_out", out_pix, 0);
        chk("rst_level", level_o, 0);
        chk("rst_stream", streaming_o, 0);
        chk("rst_ready", ready_o, 1);
        chk("rst_cnt", underflow_cnt_o, 0);
        rst_i = 1'b0;
        step();

        // Three non-frame-start words are dropped, then a prefilled frame plays and underflows.
        run_frame(3, 16'd1);

        // Two 20x8 frames with pixel strobe every cycle and a continuously valid source.
        pix_en_i = 1'b1;
        for (int n = 0; n < 320; n++) begin
            drive(mk(16'(100 + n), n % 160 == 0, n % 20 == 0));
            valid_i = 1'b1;
            if (ready_o) exp_q.push_back(mk(16'(100 + n), n % 160 == 0, n % 20 == 0));
            step();
        end
        valid_i = 1'b0;
        drain();
        chk("steady_no_uf", uf_seen, exp_uf);
        chk("steady_stream", streaming_o, 1);

        // Underflow with a push into the empty FIFO on the same cycle.
        drive(mk(16'd500, 1'b0, 1'b0));
        valid_i = 1'b1;
        pix_en_i = 1'b1;
        chk("uf_with_push", underflow_o, 1);
        step();
        valid_i = 1'b0;
        pix_en_i = 1'b0;
        exp_uf++;
        exp_cnt = bump(exp_cnt);
        chk("uf_push_fill", streaming_o, 0);
        chk("uf_push_level", level_o, 1);
        chk("uf_push_cnt", underflow_cnt_o, exp_cnt);
        step();
        chk("fill_drop", level_o, 0);

        // Fill to capacity with no strobe; excess words must be refused, none lost.
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            drive(mk(16'(600 + i), i == 0, 1'b0));
            valid_i = 1'b1;
            if (ready_o) begin
                exp_q.push_back(mk(16'(600 + i), i == 0, 1'b0));
                acc++;
            end
            step();
        end
        valid_i = 1'b0;
        chk("full_ready", ready_o, 0);
        chk("full_level", level_o, 16);
        chk("full_accepted", acc, 16);
        drain();

        // Reset held three cycles with buffered words and valid input.
        for (int i = 0; i < 4; i++) push_word(mk(16'(650 + i), 1'b1, 1'b0), 1'b0);
        rst_i = 1'b1;
        valid_i = 1'b1;
        repeat (3) step();
        exp_cnt = '0;
        chk("mid_rst_out", out_pix, 0);
        chk("mid_rst_level", level_o, 0);
        chk("mid_rst_stream", streaming_o, 0);
        chk("mid_rst_cnt", underflow_cnt_o, 0);
        rst_i = 1'b0;
        valid_i = 1'b0;
        step();
        chk("post_rst_level", level_o, 0);

`ifdef VID_OUT_FIFO_STATS_EN
        force dut.ucnt_q = 16'hFFFE;
        step();
        release dut.ucnt_q;
        exp_cnt = 16'hFFFE;
        chk("cnt_forced", underflow_cnt_o, exp_cnt);
        run_frame(0, 16'd700);
        run_frame(0, 16'd720);
`endif

        t = 0;
        repeat (3) step();
        chk("sb_empty", exp_q.size(), 0);
        chk("uf_total", uf_seen, exp_uf);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
